req_gnt_arbiter: RTL and testbench
==================================

Name: req_gnt_arbiter

Overview:
- Granting (responder) end of the four-phase req/gnt handshake, serving N_REQ requesters instead of one.
- Each requester raises req[i] and holds it until it sees gnt[i]. It drops req[i] when done, and the arbiter then drops gnt[i].
- Round-robin fairness, a programmable grant delay, an enable gate and protocol-error reporting.
- Sits between multiple masters and one shared slave resource.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- GNT_DELAY, 1, cycles from arbitration decision to gnt assertion (0..15).
- MAX_HOLD, 16, grant-hold timeout in cycles; used only with GNT_TIMEOUT_EN (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable; gates new grants only.
- req  in  N_REQ  request lines, one per requester.
- gnt  out  N_REQ  grant lines, one-hot or zero, registered.
- gnt_id  out  $clog2(N_REQ)  index of current/pending winner; valid while busy.
- busy  out  1  high in WAIT, GRANT, RELEASE.
- proto_err  out  1  one-cycle pulse on requester protocol violation.

Behaviour:
- Single clock. Reset is asynchronous, active-high.
- Reset values: state=IDLE, gnt=0, gnt_id=0, busy=0, proto_err=0, rr pointer=0, hold counter=0, blocked mask=0.
- States: IDLE, WAIT, GRANT, RELEASE.
- IDLE:
  - If en=1 and (req & ~blocked)!=0, latch winner at edge k. Winner is the first set bit at or after the pointer, wrapping N_REQ-1 -> 0.
  - Set gnt_id=winner and busy=1.
  - GNT_DELAY=0: go to GRANT and assert gnt[winner] at edge k.
  - Otherwise: load the delay counter and go to WAIT.
- WAIT:
  - Count down. gnt[winner] rises at edge k+GNT_DELAY and state moves to GRANT.
  - If req[winner] drops during WAIT: pulse proto_err, go to IDLE, busy=0. No grant is issued and the pointer is unchanged.
- GRANT:
  - gnt[winner] holds while req[winner]=1.
  - req[winner] sampled low at edge m: gnt falls at edge m, pointer=(winner+1) mod N_REQ, state moves to RELEASE.
- RELEASE: one dead cycle. State moves to IDLE at edge m+1; busy=0 at edge m+1. Earliest next arbitration is edge m+2.
- en:
  - Sampled only in IDLE.
  - Deasserting en mid-transaction does not abort; the transaction completes normally.
- Simultaneous requests are resolved by the pointer only; no fixed priority.
- Changes to req of non-winners are ignored while busy.
- blocked mask: bit i clears on any cycle req[i]=0. Without the optional feature it is never set.
- Reset mid-transaction: gnt drops immediately (asynchronous) and all state returns to reset values.
- gnt is never multi-hot. gnt[i] never rises while req[i]=0.

Optional Feature:
- Macro: GNT_TIMEOUT_EN.
- With the macro defined:
  - A hold counter counts cycles in GRANT.
  - On reaching MAX_HOLD with req[winner] still 1: gnt drops, proto_err pulses, blocked[winner]=1, pointer advances, state moves to RELEASE.
  - The blocked requester is excluded from arbitration until it deasserts req.
- Without the macro: no hold counter, no blocking, and a grant persists indefinitely.

Decomposition:
- Package req_gnt_pkg:
  - state enum typedef (IDLE, WAIT, GRANT, RELEASE).
  - localparam width helpers for the index and counters.
- One sub-module, rr_pick: purely combinational. Inputs are the request vector, mask and pointer; outputs are a valid flag and the winner index.

Test Plan (N_REQ=4, GNT_DELAY=2, MAX_HOLD=8):
- Single request: req=4'b0100 sampled at edge 10 -> busy=1, gnt_id=2 at edge 10; gnt=4'b0100 at edge 12. Drop req before edge 20 -> gnt=0 at edge 20, busy=0 at edge 21.
- Fairness: req=4'b1111, each requester completing its handshake 3 cycles after its gnt -> grant order 0,1,2,3,0,1. gnt is never multi-hot.
- Enable gating: en=0 with req=4'b0010 for 20 cycles -> gnt=0, busy=0. Raise en -> gnt=4'b0010 two edges after the first IDLE sample.
- Withdraw in WAIT: req[1] drops one cycle after winner latch -> proto_err pulses 1 cycle, gnt stays 0, next winner search still starts at the same pointer.
- Async reset during GRANT: assert rst mid-cycle -> gnt=0 and busy=0 immediately, before the next edge. After release, req=4'b1000 is granted with index 3 (pointer restarted at 0).
- GNT_TIMEOUT_EN: req[0] held forever -> gnt[0] falls after 8 GRANT cycles with a proto_err pulse. req[0] is not regranted until it goes low; req[2], if high, is granted next.

Source files
------------

// File: rtl/req_gnt_pkg.sv
// Shared state encoding and width helpers for req_gnt_arbiter and rr_pick.
package req_gnt_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_GRANT   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        WAIT    = S_WAIT,
        GRANT   = S_GRANT,
        RELEASE = S_RELEASE
    } state_e;

    // Grant delay is 0..15, so the countdown never needs more than four bits.
    localparam int DLY_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/req_gnt_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] rot;
    logic [IDX_W:0]   sum;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        cand  = req & ~mask;
        rot   = N_REQ'({cand, cand} >> ptr);
        valid = |cand;
        sum   = '0;
        // Walk from the farthest offset down so the closest set bit wins.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (rot[off]) begin
                sum = {1'b0, ptr} + (IDX_W + 1)'(off);
            end
        end
        idx = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
    end

endmodule

// File: rtl/req_gnt_arbiter.sv
// Four-phase req/gnt responder shared by N_REQ requesters with round-robin arbitration.
// Optional grant-hold timeout and requester blocking: define GNT_TIMEOUT_EN.
module req_gnt_arbiter
    import req_gnt_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int GNT_DELAY = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     proto_err
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic               busy_q, busy_d;
    logic               perr_q, perr_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [N_REQ-1:0]   blocked_q, blocked_d;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   next_ptr;
`ifdef GNT_TIMEOUT_EN
    localparam int HOLD_W = cnt_w(MAX_HOLD);
    logic [HOLD_W-1:0]  hold_q, hold_d;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .mask  (blocked_q),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign next_ptr = (id_q == LAST_IDX) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        busy_d    = busy_q;
        perr_d    = 1'b0;
        ptr_d     = ptr_q;
        dly_d     = dly_q;
        blocked_d = blocked_q & req;
`ifdef GNT_TIMEOUT_EN
        hold_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (en && pick_valid) begin
                    id_d   = pick_idx;
                    busy_d = 1'b1;
                    if (GNT_DELAY == 0) begin
                        state_d = GRANT;
                        gnt_d   = N_REQ'(1) << pick_idx;
                    end else begin
                        state_d = WAIT;
                        dly_d   = DLY_W'(GNT_DELAY);
                    end
                end
            end
            WAIT: begin
                // A withdrawn request beats an expiring delay: never grant a dropped req.
                if (!req[id_q]) begin
                    perr_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (dly_q == DLY_W'(1)) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << id_q;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            GRANT: begin
                if (!req[id_q]) begin
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    state_d = RELEASE;
                end
`ifdef GNT_TIMEOUT_EN
                else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    gnt_d           = '0;
                    perr_d          = 1'b1;
                    blocked_d[id_q] = 1'b1;
                    ptr_d           = next_ptr;
                    state_d         = RELEASE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
            ptr_q     <= '0;
            dly_q     <= '0;
            blocked_q <= '0;
`ifdef GNT_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            perr_q    <= perr_d;
            ptr_q     <= ptr_d;
            dly_q     <= dly_d;
            blocked_q <= blocked_d;
`ifdef GNT_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign busy      = busy_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Randomized and directed bench for req_gnt_arbiter with an edge-timestamp reference model
// and a queue-based scoreboard checked on the falling clock edge.
module tb_req_gnt_arbiter;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         proto_err;

    int checks   = 0;
    int failures = 0;

    req_gnt_arbiter #(
        .N_REQ     (N),
        .GNT_DELAY (D),
        .MAX_HOLD  (MH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         busy;
        logic [1:0]   id;
        logic         perr;
    } exp_t;

    exp_t sb[$];

    // Reference model state: who owns the resource and at which edges things happen.
    int           owner, ptr_m, n_edge, grant_edge, free_edge, rel_edge;
    logic [1:0]   last_id;
    logic [N-1:0] blk;

    function automatic int pick(input logic [N-1:0] cand, input int from);
        logic [1:0] p;
        for (int off = 0; off < N; off++) begin
            p = 2'((from + off) % N);
            if (cand[p]) return int'(p);
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v == (N'(1) << i)) return i;
        end
        return -1;
    endfunction

    task automatic end_grant();
        ptr_m     = (owner + 1) % N;
        rel_edge  = n_edge;
        free_edge = n_edge + 2;
        owner     = -1;
    endtask

    always @(posedge clk or posedge rst) begin : ref_model
        exp_t         e;
        logic [N-1:0] blk_set;
        logic [1:0]   o;
        if (rst) begin
            owner = -1; ptr_m = 0; n_edge = 0; grant_edge = 0;
            free_edge = 0; rel_edge = -1; last_id = '0; blk = '0;
            sb.delete();
        end else begin
            blk_set = '0;
            e       = '0;
            if (owner < 0) begin
                if (n_edge >= free_edge && en && (req & ~blk) != '0) begin
                    owner      = pick(req & ~blk, ptr_m);
                    last_id    = 2'(owner);
                    grant_edge = n_edge + D;
                end
            end else begin
                o = 2'(owner);
                if (n_edge <= grant_edge) begin
                    if (!req[o]) begin
                        e.perr    = 1'b1;
                        owner     = -1;
                        free_edge = n_edge + 1;
                    end
                end else if (!req[o]) begin
                    end_grant();
                end
`ifdef GNT_TIMEOUT_EN
                else if (n_edge - grant_edge == MH) begin
                    e.perr     = 1'b1;
                    blk_set[o] = 1'b1;
                    end_grant();
                end
`endif
            end
            if (owner >= 0 && n_edge >= grant_edge) e.gnt = N'(1) << 2'(owner);
            e.busy = (owner >= 0) || (rel_edge == n_edge);
            e.id   = last_id;
            blk    = (blk & req) | blk_set;
            n_edge++;
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_gnt", 32'(gnt), 32'(e.gnt));
            check("sb_busy", 32'(busy), 32'(e.busy));
            check("sb_proto_err", 32'(proto_err), 32'(e.perr));
            if (e.busy) check("sb_gnt_id", 32'(gnt_id), 32'(e.id));
        end
    end

    int hc[N];
    int tgt[N];
    bit seen[N];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin hc[i] = 0; seen[i] = 1'b0; end
        #3;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // One step of N well-behaved requesters, with an optional chance of early withdrawal.
    task automatic drive(input int raise_pct, input int hmin, input int hmax, input int wd_pct);
        for (int i = 0; i < N; i++) begin
            if (!req[i]) begin
                if (int'($urandom_range(0, 99)) < raise_pct) begin
                    req[i]  = 1'b1;
                    seen[i] = 1'b0;
                    hc[i]   = 0;
                    tgt[i]  = int'($urandom_range(hmin, hmax));
                end
            end else if (gnt[i]) begin
                seen[i] = 1'b1;
                hc[i]++;
                if (hc[i] >= tgt[i]) req[i] = 1'b0;
            end else if (seen[i]) begin
                req[i] = 1'b0;
            end else if (int'($urandom_range(0, 99)) < wd_pct) begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_gnt(input string name, input logic [N-1:0] want, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (gnt == want) break;
        end
        check(name, 32'(gnt), 32'(want));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int order[$];
        logic [N-1:0] prev;
        int g0, g2, perr_seen;

        rst = 1'b1; en = 1'b0; req = '0;
        #12;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        en = 1'b1;

        // Single request: latch at edge k, grant at k+2, release after req drops.
        tick(); req = 4'b0100;
        @(posedge clk); #1;
        check("single_busy", 32'(busy), 32'd1);
        check("single_id", 32'(gnt_id), 32'd2);
        check("single_gnt_k", 32'(gnt), 32'd0);
        @(posedge clk); #1 check("single_gnt_k1", 32'(gnt), 32'd0);
        @(posedge clk); #1 check("single_gnt_k2", 32'(gnt), 32'b0100);
        repeat (3) tick();
        req = '0;
        @(posedge clk); #1;
        check("single_drop_gnt", 32'(gnt), 32'd0);
        check("single_release_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 check("single_idle_busy", 32'(busy), 32'd0);

        // Fairness: all four request, each finishes three cycles after its grant.
        do_reset();
        prev = '0;
        for (int t = 0; t < 200 && order.size() < 6; t++) begin
            tick();
            if (gnt != '0 && gnt != prev) order.push_back(idx_of(gnt));
            prev = gnt;
            drive(100, 3, 3, 0);
        end
        check("fair_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < order.size(); i++) check("fair_order", 32'(order[i]), 32'(i % N));
        req = '0;
        repeat (8) tick();

        // Enable gating.
        en = 1'b0; req = 4'b0010;
        repeat (20) tick();
        check("en_off_gnt", 32'(gnt), 32'd0);
        check("en_off_busy", 32'(busy), 32'd0);
        en = 1'b1;
        @(posedge clk); #1 check("en_on_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(posedge clk); #1 check("en_on_gnt", 32'(gnt), 32'b0010);
        req = '0;
        repeat (4) tick();

        // Withdraw during WAIT leaves the pointer at 0.
        do_reset();
        en = 1'b1; req = 4'b0010;
        @(posedge clk); #1 check("wd_latch_id", 32'(gnt_id), 32'd1);
        #1 req = '0;
        @(posedge clk); #1;
        check("wd_proto_err", 32'(proto_err), 32'd1);
        check("wd_gnt", 32'(gnt), 32'd0);
        check("wd_busy", 32'(busy), 32'd0);
        req = 4'b0101;
        @(posedge clk); #1;
        check("wd_perr_pulse", 32'(proto_err), 32'd0);
        check("wd_ptr_same", 32'(gnt_id), 32'd0);
        wait_gnt("wd_regrant", 4'b0001, 10);
        req = '0;
        repeat (4) tick();

        // Asynchronous reset during GRANT.
        req = 4'b0001;
        wait_gnt("ar_grant", 4'b0001, 12);
        rst = 1'b1;
        #1;
        check("ar_gnt_async", 32'(gnt), 32'd0);
        check("ar_busy_async", 32'(busy), 32'd0);
        req = 4'b1000;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("ar_busy_after", 32'(busy), 32'd1);
        check("ar_id_after", 32'(gnt_id), 32'd3);
        wait_gnt("ar_regrant", 4'b1000, 10);
        req = '0;
        repeat (4) tick();

`ifdef GNT_TIMEOUT_EN
        // Grant-hold timeout: req[0] never drops; req[2] is served next.
        do_reset();
        order.delete();
        prev = '0; g0 = 0; g2 = 0; perr_seen = 0;
        req = 4'b0101;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (proto_err) perr_seen++;
            if (gnt != '0 && gnt != prev) order.push_back(idx_of(gnt));
            prev = gnt;
            if (gnt == 4'b0001) g0++;
            if (gnt == 4'b0100) begin
                g2++;
                if (g2 == 3) req[2] = 1'b0;
            end
        end
        check("to_hold_cycles", 32'(g0), 32'(MH));
        check("to_proto_err", 32'(perr_seen), 32'd1);
        check("to_grant_count", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            check("to_first", 32'(order[0]), 32'd0);
            check("to_second", 32'(order[1]), 32'd2);
        end
        req = '0;
        tick();
        req = 4'b0001;
        wait_gnt("to_unblocked", 4'b0001, 12);
        req = '0;
        repeat (4) tick();
`else
        g0 = 0; g2 = 0; perr_seen = 0;
`endif

        // Randomized traffic with enable toggling and occasional early withdrawal.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            tick();
            en = (int'($urandom_range(0, 9)) != 0);
            drive(30, 1, 11, 3);
        end
        req = '0;
        repeat (6) tick();
        check("end_idle_gnt", 32'(gnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
